hash_rate_meter: RTL
====================

# hash_rate_meter

Consumer of the one-second `second_tick` pulse produced by the design's timer. Counts hash-completion events from the accelerator cores across each full tick-to-tick window and publishes a hashes-per-second sample through a valid/ready output. It sits between the hash core array and the host status/readout path, and discards partial windows after reset or enable.

## Interface

Parameters:
- `INC_W`, default 4: width of the per-cycle event increment. Supports up to 2^INC_W-1 core completions per cycle.
- `CNT_W`, default 32: width of the window accumulator and of the published sample.

Ports:
- `clk`, input, 1: single clock. All logic is rising-edge.
- `rst_i`, input, 1: synchronous, active-high reset.
- `enable`, input, 1: measurement enable. Low means idle and resynchronise.
- `second_tick`, input, 1: one-cycle pulse from the timer marking a window boundary.
- `event_inc_i`, input, INC_W: number of hash completions in this cycle.
- `rate_o`, output, CNT_W: last published events-per-window sample.
- `rate_valid_o`, output, 1: `rate_o` holds an unconsumed sample.
- `rate_ready_i`, input, 1: consumer accepts the sample when `rate_valid_o && rate_ready_i`.
- `sat_o`, output, 1: the sample in `rate_o` was clamped.
- `overrun_o`, output, 1: sticky flag. An unconsumed sample was overwritten.
- `synced_o`, output, 1: the FSM is in MEASURE.

## Operation

- FSM has two states, WAIT_SYNC and MEASURE. Reset state is WAIT_SYNC.
  - WAIT_SYNC: accumulator is held at 0 and `event_inc_i` is ignored. Moves to MEASURE on `enable && second_tick`; the accumulator starts from 0 the next cycle.
  - MEASURE: `acc <= sat(acc + event_inc_i)` every cycle.
  - On `second_tick` in MEASURE:
    - The closing sample is `sat(acc + event_inc_i)`, so events in the tick cycle belong to the closing window.
    - The sample loads into `rate_o`, `sat_o` is updated, `rate_valid_o` is set, and `acc <= 0`.
  - `enable` low in any state: go to WAIT_SYNC and clear `acc`. `rate_o`, `rate_valid_o`, `sat_o` and `overrun_o` are held, and the handshake continues.
- Saturation:
  - Arithmetic is unsigned and CNT_W+1 wide internally.
  - A result above 2^CNT_W-1 clamps to 2^CNT_W-1, and the window's saturated bit is set.
  - The saturated bit clears when a new window starts.
- Handshake:
  - A sample is consumed on any cycle with `rate_valid_o && rate_ready_i`.
  - `rate_o` and `sat_o` must stay stable while valid and not consumed.
- Simultaneous tick and consume in the same cycle: the new sample loads, `rate_valid_o` stays 1, and `overrun_o` is not set.
- Tick while valid and not ready: the new sample overwrites the old one and `overrun_o` is set to 1. It stays 1 until `rst_i`.
- `rst_i` has priority over all inputs. It clears the state, `acc`, `rate_o`, `rate_valid_o`, `sat_o` and `overrun_o` in the same edge.

## Timing

- Reset values: `rate_o`=0, `rate_valid_o`=0, `sat_o`=0, `overrun_o`=0, `synced_o`=0.
- Latency:
  - Tick at cycle T: `rate_o` and `rate_valid_o` update at the edge ending T and are visible in T+1.
  - Sync tick at cycle T: `synced_o` is high from T+1.
- The first tick after reset or enable only synchronises. The first sample is published on the second tick.
- Back-to-back ticks (window of 1 cycle) are legal. The sample equals `event_inc_i` of the second tick cycle.
- `rate_ready_i` may be high with valid low; this has no effect.
- Throughput: one sample per tick. No internal queue.

## Test plan

1. Reset, hold `enable`=1, tick at cycles 2 and 12, `event_inc_i`=3 on every cycle between them (cycles 3..12 inclusive) -> one sample, `rate_o`=30, `rate_valid_o`=1, `sat_o`=0, `overrun_o`=0.
2. Same stimulus with `rate_ready_i`=0, then a third tick 10 cycles later with `event_inc_i`=1 -> `rate_o`=10, `overrun_o`=1. Then assert ready -> valid drops next cycle, `overrun_o` stays 1.
3. Tick and `rate_ready_i` high in the same cycle while valid -> new sample loaded, `rate_valid_o` stays 1, `overrun_o`=0.
4. CNT_W=8, `event_inc_i`=15 for 20 cycles between ticks (raw 300) -> `rate_o`=255, `sat_o`=1. Next window with 5 events -> `rate_o`=5, `sat_o`=0.
5. Mid-window drop `enable` for 3 cycles, then re-enable -> `synced_o`=0 and `acc` cleared. The next tick only resyncs, and the previous `rate_o` is held. The following tick publishes only post-resync events.
6. Assert `rst_i` in the same cycle as a tick with valid high -> the next cycle shows all outputs 0 and the FSM in WAIT_SYNC. No sample is published.

Source files
------------

// File: rtl/hash_rate_meter_if.sv
// Sample/handshake bundle between the hash core array, the meter and the status readout path.
interface hash_rate_meter_if #(
  parameter int unsigned INC_W = 4,
  parameter int unsigned CNT_W = 32
) ();

  logic             enable;
  logic             second_tick;
  logic [INC_W-1:0] event_inc_i;
  logic [CNT_W-1:0] rate_o;
  logic             rate_valid_o;
  logic             rate_ready_i;
  logic             sat_o;
  logic             overrun_o;
  logic             synced_o;

  // Driving side: timer, core array and sample consumer
  modport master (
    output enable,
    output second_tick,
    output event_inc_i,
    output rate_ready_i,
    input  rate_o,
    input  rate_valid_o,
    input  sat_o,
    input  overrun_o,
    input  synced_o
  );

  // Meter side
  modport slave (
    input  enable,
    input  second_tick,
    input  event_inc_i,
    input  rate_ready_i,
    output rate_o,
    output rate_valid_o,
    output sat_o,
    output overrun_o,
    output synced_o
  );

endinterface

// File: rtl/hash_rate_meter.sv
// Hashes-per-second meter: accumulates completion events across full
// tick-to-tick windows and publishes one saturating sample per tick.
module hash_rate_meter #(
  parameter int unsigned INC_W = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_i,
  hash_rate_meter_if.slave  bus
);

  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    MEASURE   = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             win_sat_q, win_sat_d;
  logic [CNT_W-1:0] rate_q, rate_d;
  logic             valid_q, valid_d;
  logic             sat_q, sat_d;
  logic             overrun_q, overrun_d;

  logic [SUM_W-1:0] sum_c;
  logic [CNT_W-1:0] sum_sat_c;
  logic             sum_ovf_c;
  logic             consume_c;

  // Widened add with clamp; the window saturated bit is sticky until the window closes
  always_comb begin
    sum_c     = SUM_W'(acc_q) + SUM_W'(bus.event_inc_i);
    sum_ovf_c = sum_c[CNT_W];
    sum_sat_c = sum_ovf_c ? CNT_MAX : sum_c[CNT_W-1:0];
    consume_c = valid_q & bus.rate_ready_i;
  end

  // Next-state, accumulator and sample register logic
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    win_sat_d = win_sat_q;
    rate_d    = rate_q;
    sat_d     = sat_q;
    valid_d   = valid_q & ~consume_c;
    overrun_d = overrun_q;

    if (!bus.enable) begin
      // Idle: drop the partial window; the published sample and handshake are untouched
      state_d   = WAIT_SYNC;
      acc_d     = '0;
      win_sat_d = 1'b0;
    end else begin
      unique case (state_q)
        WAIT_SYNC: begin
          acc_d     = '0;
          win_sat_d = 1'b0;
          if (bus.second_tick) begin
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          if (bus.second_tick) begin
            // Tick-cycle events close out the current window
            rate_d    = sum_sat_c;
            sat_d     = win_sat_q | sum_ovf_c;
            valid_d   = 1'b1;
            acc_d     = '0;
            win_sat_d = 1'b0;
            if (valid_q && !bus.rate_ready_i) begin
              overrun_d = 1'b1;
            end
          end else begin
            acc_d     = sum_sat_c;
            win_sat_d = win_sat_q | sum_ovf_c;
          end
        end
        default: begin
          state_d = WAIT_SYNC;
          acc_d   = '0;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q   <= WAIT_SYNC;
      acc_q     <= '0;
      win_sat_q <= 1'b0;
      rate_q    <= '0;
      valid_q   <= 1'b0;
      sat_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      win_sat_q <= win_sat_d;
      rate_q    <= rate_d;
      valid_q   <= valid_d;
      sat_q     <= sat_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.rate_o       = rate_q;
  assign bus.rate_valid_o = valid_q;
  assign bus.sat_o        = sat_q;
  assign bus.overrun_o    = overrun_q;
  assign bus.synced_o     = (state_q == MEASURE);

endmodule
